// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI raster timing controller.
//   state_e  : controller FSM state
//   coord_t  : 12-bit raster coordinate / counter value
//   HVE_*    : bit positions inside the {display_enable, vsync, hsync} bundle
package hdmi_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  typedef logic [11:0] coord_t;

  localparam int unsigned COORD_RANGE = 4096;

  localparam int unsigned HVE_DE    = 2;
  localparam int unsigned HVE_VSYNC = 1;
  localparam int unsigned HVE_HSYNC = 0;

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Video timing bundle between the raster controller and the TMDS encoder path.
//   i_enable      : run request (level)
//   o_hve_sync    : {display_enable, vsync, hsync}
//   o_x / o_y     : pixel coordinates, aligned with o_hve_sync
//   o_line_start  : pulse on the first pixel of each line
//   o_frame_start : pulse on the first pixel of each frame
//   o_busy        : controller is running or finishing a frame
//   o_frame_cnt   : frame counter, only with HDMI_TIMING_FRAME_CNT_EN
// Modports: master = timing controller, slave = consumer / driver of i_enable.
interface hdmi_video_timing_if;
  import hdmi_timing_pkg::*;

  logic        i_enable;
  logic [2:0]  o_hve_sync;
  coord_t      o_x;
  coord_t      o_y;
  logic        o_line_start;
  logic        o_frame_start;
  logic        o_busy;
`ifdef HDMI_TIMING_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  modport master (
    input  i_enable,
    output o_hve_sync,
    output o_x,
    output o_y,
    output o_line_start,
    output o_frame_start,
`ifdef HDMI_TIMING_FRAME_CNT_EN
    output o_frame_cnt,
`endif
    output o_busy
  );

  modport slave (
    output i_enable,
    input  o_hve_sync,
    input  o_x,
    input  o_y,
    input  o_line_start,
    input  o_frame_start,
`ifdef HDMI_TIMING_FRAME_CNT_EN
    input  o_frame_cnt,
`endif
    input  o_busy
  );

endinterface

// File: rtl/hdmi_timing_axis.sv
// One raster axis: a counter sweeping active, front porch, sync and back porch.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_step           : advance one position (wraps TOTAL-1 -> 0)
//   i_clear          : force the counter to 0 (has priority over i_step)
//   o_count          : current position
//   o_wrap           : counter sits on its last position (TOTAL-1)
//   o_active         : position lies inside the active span
//   o_sync           : sync level for this position (POL inside the sync span)
module hdmi_timing_axis
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 1280,
  parameter int unsigned FRONT  = 110,
  parameter int unsigned SYNC   = 40,
  parameter int unsigned BACK   = 220,
  parameter bit          POL    = 1'b1
) (
  input  logic   i_clk,
  input  logic   i_reset_n,
  input  logic   i_step,
  input  logic   i_clear,
  output coord_t o_count,
  output logic   o_wrap,
  output logic   o_active,
  output logic   o_sync
);

  localparam int unsigned TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam int unsigned SYNC_START = ACTIVE + FRONT;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  coord_t      r_count;
  int unsigned w_pos;
  logic        w_in_sync;

  // Widen once so span limits up to 4096 compare correctly.
  assign w_pos = 32'(r_count);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_step) begin
      r_count <= o_wrap ? '0 : r_count + 12'd1;
    end
  end

  assign w_in_sync = (w_pos >= SYNC_START) && (w_pos < SYNC_END);

  assign o_count  = r_count;
  assign o_wrap   = (w_pos == TOTAL - 1);
  assign o_active = (w_pos < ACTIVE);
  assign o_sync   = w_in_sync ? POL : ~POL;

endmodule

// File: rtl/hdmi_video_timing.sv
// HDMI raster timing controller. Sweeps h/v counters and drives registered
// {display_enable, vsync, hsync}, pixel coordinates and line/frame pulses.
// Runs start and stop only on frame boundaries.
// Ports:
//   i_hdmi_clk : pixel clock
//   i_reset_n  : asynchronous active-low reset
//   bus        : hdmi_video_timing_if.master (enable in, timing outputs out)
// Build option: HDMI_TIMING_FRAME_CNT_EN adds a 16-bit frame counter (o_frame_cnt).
module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FRONT    = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BACK     = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FRONT    = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BACK     = 20,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1
) (
  input logic                 i_hdmi_clk,
  input logic                 i_reset_n,
  hdmi_video_timing_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_total_check
    $error("hdmi_video_timing: H_TOTAL/V_TOTAL must not exceed 4096");
  end

  state_e     r_state;
  state_e     w_state_next;
  logic       w_run;

  coord_t     w_h_count;
  coord_t     w_v_count;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_h_active;
  logic       w_v_active;
  logic       w_h_sync;
  logic       w_v_sync;
  logic       w_frame_last;

  logic [2:0] w_hve_next;
  logic       w_line_start_next;
  logic       w_frame_start_next;

  logic [2:0] r_hve_sync;
  coord_t     r_x;
  coord_t     r_y;
  logic       r_line_start;
  logic       r_frame_start;
  logic       r_busy;

  assign w_run        = (r_state != ST_IDLE);
  assign w_frame_last = w_h_wrap && w_v_wrap;

  // Counters are held at 0 while idle so every run begins at pixel (0,0).
  hdmi_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (H_SYNC_POL)
  ) u_h_axis (
    .i_clk     (i_hdmi_clk),
    .i_reset_n (i_reset_n),
    .i_step    (w_run),
    .i_clear   (!w_run),
    .o_count   (w_h_count),
    .o_wrap    (w_h_wrap),
    .o_active  (w_h_active),
    .o_sync    (w_h_sync)
  );

  hdmi_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (V_SYNC_POL)
  ) u_v_axis (
    .i_clk     (i_hdmi_clk),
    .i_reset_n (i_reset_n),
    .i_step    (w_run && w_h_wrap),
    .i_clear   (!w_run),
    .o_count   (w_v_count),
    .o_wrap    (w_v_wrap),
    .o_active  (w_v_active),
    .o_sync    (w_v_sync)
  );

  // FSM state register.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A re-raised enable beats the end-of-frame exit, so the frame wraps normally.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_enable) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.i_enable) w_state_next = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (bus.i_enable) begin
          w_state_next = ST_RUN;
        end else if (w_frame_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode; outside a run the bundle shows its idle levels.
  always_comb begin
    w_hve_next            = {1'b0, ~V_SYNC_POL, ~H_SYNC_POL};
    w_line_start_next     = 1'b0;
    w_frame_start_next    = 1'b0;
    if (w_run) begin
      w_hve_next[HVE_DE]    = w_h_active && w_v_active;
      w_hve_next[HVE_VSYNC] = w_v_sync;
      w_hve_next[HVE_HSYNC] = w_h_sync;
      w_line_start_next     = (w_h_count == '0);
      w_frame_start_next    = (w_h_count == '0) && (w_v_count == '0);
    end
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hve_sync    <= {1'b0, ~V_SYNC_POL, ~H_SYNC_POL};
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_hve_sync    <= w_hve_next;
      r_x           <= w_h_count;
      r_y           <= w_v_count;
      r_line_start  <= w_line_start_next;
      r_frame_start <= w_frame_start_next;
      r_busy        <= w_run;
    end
  end

  assign bus.o_hve_sync    = r_hve_sync;
  assign bus.o_x           = r_x;
  assign bus.o_y           = r_y;
  assign bus.o_line_start  = r_line_start;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_busy        = r_busy;

`ifdef HDMI_TIMING_FRAME_CNT_EN
  // Counts in step with o_frame_start, so the pulse cycle already shows the new value.
  logic [15:0] r_frame_cnt;

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start_next) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing on a small raster:
// H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), both sync polarities 1, 48-cycle frame.
module tb_hdmi_video_timing;
  import hdmi_timing_pkg::*;

  // {hve[2:0], x[11:0], y[11:0], line_start, frame_start, busy}
  typedef logic [29:0] obs_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;               // frame position of the currently visible outputs
  int de_cnt = 0;
  logic [15:0] exp_fcnt = '0;

  always #5 clk = ~clk;

  hdmi_video_timing_if bus ();

  hdmi_video_timing #(
    .H_ACTIVE   (4),
    .H_FRONT    (1),
    .H_SYNC     (2),
    .H_BACK     (1),
    .V_ACTIVE   (3),
    .V_FRONT    (1),
    .V_SYNC     (1),
    .V_BACK     (1),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b1)
  ) dut (
    .i_hdmi_clk (clk),
    .i_reset_n  (rst_n),
    .bus        (bus)
  );

  function automatic obs_t pack(input logic [2:0] hve, input int x, input int y,
                                input logic ls, input logic fs, input logic busy);
    return {hve, 12'(x), 12'(y), ls, fs, busy};
  endfunction

  function automatic obs_t actual();
    return {bus.o_hve_sync, bus.o_x, bus.o_y, bus.o_line_start, bus.o_frame_start,
            bus.o_busy};
  endfunction

  // Expected outputs while running, at frame position p.
  function automatic obs_t model(input int p);
    int x;
    int y;
    logic de;
    logic vs;
    logic hs;
    x  = p % 8;
    y  = p / 8;
    de = (x < 4) && (y < 3);
    vs = (y == 4);
    hs = (x == 5) || (x == 6);
    return pack({de, vs, hs}, x, y, x == 0, p == 0, 1'b1);
  endfunction

  localparam obs_t IDLE_OBS = 30'd0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hve=%b x=%0d y=%0d ls=%b fs=%b busy=%b, want hve=%b x=%0d y=%0d ls=%b fs=%b busy=%b",
               name, act[29:27], act[26:15], act[14:3], act[2], act[1], act[0],
               exp[29:27], exp[26:15], exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fcnt(input string name);
`ifdef HDMI_TIMING_FRAME_CNT_EN
    check_val(name, int'(bus.o_frame_cnt), int'(exp_fcnt));
`else
    if (name.len() == 0) $display("empty check name");
`endif
  endtask

  // Advance n cycles in a running frame, checking every output cycle.
  task automatic run_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      k = (k + 1) % 48;
      if (k == 0) begin
        exp_fcnt = exp_fcnt + 16'd1;
        de_cnt = 0;
      end
      check($sformatf("%s k=%0d", name, k), actual(), model(k));
      check_fcnt($sformatf("%s_fcnt k=%0d", name, k));
      if (bus.o_hve_sync[HVE_DE]) de_cnt++;
      if (k == 47) check_val("de_per_frame", de_cnt, 12);
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s #%0d", name, i), actual(), IDLE_OBS);
      check_fcnt($sformatf("%s_fcnt #%0d", name, i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];

    // Enable asserted from idle: one idle output cycle, then pixel (0,0) and line 0.
    vecs[0] = '{1'b1, pack(3'b000, 0, 0, 1'b0, 1'b0, 1'b0)};
    vecs[1] = '{1'b1, pack(3'b100, 0, 0, 1'b1, 1'b1, 1'b1)};
    vecs[2] = '{1'b1, pack(3'b100, 1, 0, 1'b0, 1'b0, 1'b1)};
    vecs[3] = '{1'b1, pack(3'b100, 2, 0, 1'b0, 1'b0, 1'b1)};
    vecs[4] = '{1'b1, pack(3'b100, 3, 0, 1'b0, 1'b0, 1'b1)};
    vecs[5] = '{1'b1, pack(3'b000, 4, 0, 1'b0, 1'b0, 1'b1)};
    vecs[6] = '{1'b1, pack(3'b001, 5, 0, 1'b0, 1'b0, 1'b1)};
    vecs[7] = '{1'b1, pack(3'b001, 6, 0, 1'b0, 1'b0, 1'b1)};
    vecs[8] = '{1'b1, pack(3'b000, 7, 0, 1'b0, 1'b0, 1'b1)};
    vecs[9] = '{1'b1, pack(3'b100, 0, 1, 1'b1, 1'b0, 1'b1)};

    // 1. Reset, then idle with enable low.
    bus.i_enable = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_hold", actual(), IDLE_OBS);
    check_fcnt("reset_fcnt");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(20, "idle_after_reset");

    // 2. Start latency and first line from the table.
    de_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.i_enable = vecs[i].en;
      tick();
      if (vecs[i].exp[1]) exp_fcnt = exp_fcnt + 16'd1;
      check($sformatf("start_vec%0d", i), actual(), vecs[i].exp);
      check_fcnt($sformatf("start_vec%0d_fcnt", i));
      if (bus.o_hve_sync[HVE_DE]) de_cnt++;
    end
    k = 8;

    // 3. Steady run over several frames, stopping at x=2,y=1.
    run_cycles(146, "steady");

    // 4. Drop enable mid-frame: the frame completes, then everything goes idle.
    bus.i_enable = 1'b0;
    run_cycles(37, "stopping");
    idle_cycles(12, "stopped_idle");

    // 5. Restart, drop enable at y=1, re-raise at y=3: no disturbance, busy stays high.
    bus.i_enable = 1'b1;
    tick();
    check("restart_latency", actual(), IDLE_OBS);
    k = 47;
    run_cycles(13, "restart");
    bus.i_enable = 1'b0;
    run_cycles(12, "stop_req");
    bus.i_enable = 1'b1;
    run_cycles(33, "resumed");

    // 6. Asynchronous reset mid-frame at x=1,y=2 with enable held high.
    run_cycles(8, "pre_reset");
    check_val("pre_reset_pos", k, 17);
    #2;
    rst_n = 1'b0;
    #1;
    exp_fcnt = '0;
    check("async_reset", actual(), IDLE_OBS);
    check_fcnt("async_reset_fcnt");
    tick();
    check("reset_held", actual(), IDLE_OBS);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset_restart_edge1", actual(), IDLE_OBS);
    k = 47;
    de_cnt = 0;
    run_cycles(97, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
